// File: rtl/dbg_cpu_ctl.sv
// dbg_cpu_ctl: debug run-control FSM (run/halt/single-step with watchdog) plus CPU_CTL/CPU_STAT registers
module dbg_cpu_ctl #(
  parameter int NUM_BRK = 4,
  parameter int STEP_TO = 64
) (
  input  logic               mclk,
  input  logic               por_n,
  input  logic [15:0]        dbg_din,
  input  logic               ctl_reg_wr,
  input  logic               ctl_reg_rd,
  input  logic               stat_reg_wr,
  input  logic               stat_reg_rd,
  input  logic [NUM_BRK-1:0] brk_halt,
  input  logic [NUM_BRK-1:0] brk_pnd,
  input  logic               cpu_halt_st,
  input  logic               exec_done,
  output logic               dbg_halt_cmd,
  output logic               dbg_freeze,
  output logic               dbg_cpu_reset,
  output logic [15:0]        ctl_dout
);
  localparam int CW = $clog2(STEP_TO + 1);
  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic frz_en, cpu_rst, brk_flag, done_flag, to_flag;
  logic set_brk, set_done, set_to;
  logic halt_c, run_c, step_c, brk, timeout;
  logic [15:0] ctl_img, stat_img;
  logic unused_din;
  // HALT > RUN > ISTEP when several command bits arrive in one write
  assign halt_c  = ctl_reg_wr & dbg_din[0];
  assign run_c   = ctl_reg_wr & dbg_din[1] & ~dbg_din[0];
  assign step_c  = ctl_reg_wr & dbg_din[2] & ~|dbg_din[1:0];
  assign brk     = |brk_halt;
  assign timeout = cnt == CW'(STEP_TO - 1);
  assign unused_din = ^dbg_din[15:5];
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    set_brk   = 1'b0;
    set_done  = 1'b0;
    set_to    = 1'b0;
    if (cpu_rst) state_nxt = (state == STEP) ? HALT : state;
    else case (state)
      RUN: begin
        state_nxt = (halt_c | brk) ? HALT : RUN;
        set_brk   = brk;
      end
      HALT: begin
        if (run_c) begin
          state_nxt = brk ? HALT : RUN;
          set_brk   = brk;
        end else if (step_c & cpu_halt_st) begin
          state_nxt = STEP;
          cnt_nxt   = '0;
        end
      end
      STEP: begin
        cnt_nxt   = cnt + 1'b1;
        set_brk   = brk;
        set_done  = exec_done;
        set_to    = timeout & ~exec_done;
        state_nxt = (halt_c | brk | exec_done | timeout) ? HALT : run_c ? RUN : STEP;
      end
      default: state_nxt = RUN;
    endcase
  end
  always_ff @(posedge mclk or negedge por_n) begin
    if (!por_n) begin
      state     <= RUN;
      cnt       <= '0;
      frz_en    <= 1'b0;
      cpu_rst   <= 1'b0;
      brk_flag  <= 1'b0;
      done_flag <= 1'b0;
      to_flag   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ctl_reg_wr) {cpu_rst, frz_en} <= dbg_din[4:3];
      brk_flag  <= set_brk  | (brk_flag  & ~(stat_reg_wr & dbg_din[1]));
      done_flag <= set_done | (done_flag & ~(stat_reg_wr & dbg_din[2]));
      to_flag   <= set_to   | (to_flag   & ~(stat_reg_wr & dbg_din[3]));
    end
  end
  assign dbg_halt_cmd  = state == HALT;
  assign dbg_freeze    = cpu_halt_st & frz_en;
  assign dbg_cpu_reset = cpu_rst;
  assign ctl_img  = {11'b0, cpu_rst, frz_en, 3'b0};
  assign stat_img = 16'({brk_pnd, to_flag, done_flag, brk_flag, cpu_halt_st});
  assign ctl_dout = (ctl_reg_rd ? ctl_img : 16'h0) | (stat_reg_rd ? stat_img : 16'h0);
endmodule

// File: tb/tb_dbg_cpu_ctl.sv
// tb_dbg_cpu_ctl: directed scenarios plus randomized run against a behavioural run-control model
module tb_dbg_cpu_ctl;
  localparam int NB = 4;
  localparam int ST = 8;
  logic mclk = 0, por_n = 0;
  logic [15:0] dbg_din = '0;
  logic ctl_reg_wr = 0, ctl_reg_rd = 0, stat_reg_wr = 0, stat_reg_rd = 0;
  logic [NB-1:0] brk_halt = '0, brk_pnd = '0;
  logic cpu_halt_st = 0, exec_done = 0;
  logic dbg_halt_cmd, dbg_freeze, dbg_cpu_reset;
  logic [15:0] ctl_dout;
  int tests = 0, fails = 0;
  // model: m_st 0=running 1=halted 2=stepping; m_el = cycles spent in the current step
  int m_st, m_el;
  bit m_frz, m_rst, m_bf, m_df, m_tf;

  dbg_cpu_ctl #(.NUM_BRK(NB), .STEP_TO(ST)) dut (
    .mclk(mclk), .por_n(por_n), .dbg_din(dbg_din),
    .ctl_reg_wr(ctl_reg_wr), .ctl_reg_rd(ctl_reg_rd),
    .stat_reg_wr(stat_reg_wr), .stat_reg_rd(stat_reg_rd),
    .brk_halt(brk_halt), .brk_pnd(brk_pnd),
    .cpu_halt_st(cpu_halt_st), .exec_done(exec_done),
    .dbg_halt_cmd(dbg_halt_cmd), .dbg_freeze(dbg_freeze),
    .dbg_cpu_reset(dbg_cpu_reset), .ctl_dout(ctl_dout)
  );

  always #5 mclk = ~mclk;

  function automatic void model_reset();
    m_st = 0; m_el = 0; m_frz = 0; m_rst = 0; m_bf = 0; m_df = 0; m_tf = 0;
  endfunction

  function automatic void model_edge();
    bit hc, rc, sc, bk, sb, sd, stt, to;
    int n_st;
    hc = ctl_reg_wr && dbg_din[0];
    rc = ctl_reg_wr && dbg_din[1] && !dbg_din[0];
    sc = ctl_reg_wr && dbg_din[2] && !dbg_din[1] && !dbg_din[0];
    bk = brk_halt != 0;
    sb = 0; sd = 0; stt = 0; n_st = m_st;
    if (m_rst) begin
      if (m_st == 2) n_st = 1;
    end else if (m_st == 0) begin
      if (hc || bk) n_st = 1;
      sb = bk;
    end else if (m_st == 1) begin
      if (rc) begin
        n_st = bk ? 1 : 0;
        sb = bk;
      end else if (sc && cpu_halt_st) begin
        n_st = 2;
        m_el = 0;
      end
    end else begin
      m_el++;
      to = m_el == ST;
      sb = bk; sd = exec_done; stt = to && !exec_done;
      if (hc || bk || exec_done || to) n_st = 1;
      else if (rc) n_st = 0;
    end
    m_bf = sb  || (m_bf && !(stat_reg_wr && dbg_din[1]));
    m_df = sd  || (m_df && !(stat_reg_wr && dbg_din[2]));
    m_tf = stt || (m_tf && !(stat_reg_wr && dbg_din[3]));
    if (ctl_reg_wr) begin
      m_frz = dbg_din[3];
      m_rst = dbg_din[4];
    end
    m_st = n_st;
  endfunction

  task automatic clk1();
    @(posedge mclk);
    if (!por_n) model_reset(); else model_edge();
    #1;
  endtask

  task automatic idle();
    ctl_reg_wr = 0; stat_reg_wr = 0; ctl_reg_rd = 0; stat_reg_rd = 0;
    brk_halt = '0; exec_done = 0; dbg_din = '0;
  endtask

  task automatic wr_ctl(input logic [15:0] v);
    dbg_din = v; ctl_reg_wr = 1; clk1(); idle();
  endtask

  task automatic wr_stat(input logic [15:0] v);
    dbg_din = v; stat_reg_wr = 1; clk1(); idle();
  endtask

  task automatic rd_stat(output logic [15:0] v);
    stat_reg_rd = 1; #1; v = ctl_dout; stat_reg_rd = 0;
  endtask

  task automatic rd_ctl(output logic [15:0] v);
    ctl_reg_rd = 1; #1; v = ctl_dout; ctl_reg_rd = 0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    por_n = 0; idle(); cpu_halt_st = 0; brk_pnd = '0;
    repeat (3) clk1();
    por_n = 1;
    clk1();
    tests++; if (dbg_halt_cmd !== 1'b0) begin fails++; $display("FAIL reset_halt got %b want 0", dbg_halt_cmd); end
    tests++; if (dbg_freeze !== 1'b0 || dbg_cpu_reset !== 1'b0) begin fails++; $display("FAIL reset_frz_rst got %b%b want 00", dbg_freeze, dbg_cpu_reset); end
    rd_stat(v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL reset_stat got %h want 0000", v); end
    rd_ctl(v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL reset_ctl got %h want 0000", v); end
  endtask

  task automatic test_halt_run();
    logic [15:0] v;
    wr_ctl(16'h0001);
    tests++; if (dbg_halt_cmd !== 1'b1) begin fails++; $display("FAIL halt_cmd got %b want 1", dbg_halt_cmd); end
    wr_ctl(16'h0002);
    tests++; if (dbg_halt_cmd !== 1'b0) begin fails++; $display("FAIL run_cmd got %b want 0", dbg_halt_cmd); end
    rd_stat(v);
    tests++; if (v[1] !== 1'b0) begin fails++; $display("FAIL run_no_brkflag got %b want 0", v[1]); end
  endtask

  task automatic test_brk();
    logic [15:0] v;
    brk_pnd = 4'b0100; brk_halt = 4'b0100; clk1(); idle();
    tests++; if (dbg_halt_cmd !== 1'b1) begin fails++; $display("FAIL brk_halt got %b want 1", dbg_halt_cmd); end
    rd_stat(v);
    tests++; if (v !== 16'h0042) begin fails++; $display("FAIL brk_stat got %h want 0042", v); end
    wr_stat(16'h0002);
    rd_stat(v);
    tests++; if (v !== 16'h0040) begin fails++; $display("FAIL brk_clear got %h want 0040", v); end
    brk_pnd = 4'b1001;
    rd_stat(v);
    tests++; if (v !== 16'h0090) begin fails++; $display("FAIL brk_pnd_live got %h want 0090", v); end
    brk_halt = 4'b0010; clk1(); idle();
    rd_stat(v);
    tests++; if (v[1] !== 1'b0 || dbg_halt_cmd !== 1'b1) begin fails++; $display("FAIL brk_in_halt got flag=%b halt=%b want 0 1", v[1], dbg_halt_cmd); end
    brk_pnd = '0;
  endtask

  task automatic test_step_done();
    logic [15:0] v;
    int low;
    cpu_halt_st = 1;
    wr_ctl(16'h0004);
    low = 0;
    for (int i = 1; i <= 4; i++) begin
      if (dbg_halt_cmd === 1'b0) low++;
      if (i == 4) exec_done = 1;
      clk1();
      exec_done = 0;
    end
    tests++; if (low !== 4) begin fails++; $display("FAIL step_low_cycles got %0d want 4", low); end
    tests++; if (dbg_halt_cmd !== 1'b1) begin fails++; $display("FAIL step_back_halt got %b want 1", dbg_halt_cmd); end
    rd_stat(v);
    tests++; if (v !== 16'h0005) begin fails++; $display("FAIL step_done_stat got %h want 0005", v); end
    wr_stat(16'h0004);
  endtask

  task automatic test_step_timeout();
    logic [15:0] v;
    int n;
    wr_ctl(16'h0004);
    n = 0;
    while (dbg_halt_cmd === 1'b0 && n < 20) begin n++; clk1(); end
    tests++; if (n !== ST) begin fails++; $display("FAIL step_to_cycles got %0d want %0d", n, ST); end
    rd_stat(v);
    tests++; if (v !== 16'h0009) begin fails++; $display("FAIL step_to_stat got %h want 0009", v); end
    wr_stat(16'h000E);
    cpu_halt_st = 0;
    wr_ctl(16'h0004);
    clk1(); clk1();
    tests++; if (dbg_halt_cmd !== 1'b1) begin fails++; $display("FAIL istep_not_halted got %b want 1", dbg_halt_cmd); end
    rd_stat(v);
    tests++; if (v !== 16'h0000) begin fails++; $display("FAIL istep_not_halted_stat got %h want 0000", v); end
    cpu_halt_st = 1;
  endtask

  task automatic test_cmd_prio();
    logic [15:0] v;
    wr_ctl(16'h0006);
    repeat (ST + 2) clk1();
    tests++; if (dbg_halt_cmd !== 1'b0) begin fails++; $display("FAIL run_over_istep got %b want 0", dbg_halt_cmd); end
    wr_ctl(16'h0003);
    tests++; if (dbg_halt_cmd !== 1'b1) begin fails++; $display("FAIL halt_over_run got %b want 1", dbg_halt_cmd); end
    dbg_din = 16'h0002; ctl_reg_wr = 1; brk_halt = 4'b0001; clk1(); idle();
    rd_stat(v);
    tests++; if (dbg_halt_cmd !== 1'b1 || v[1] !== 1'b1) begin fails++; $display("FAIL brk_with_run got halt=%b flag=%b want 1 1", dbg_halt_cmd, v[1]); end
    wr_stat(16'h0002);
  endtask

  task automatic test_freeze_rst();
    logic [15:0] v;
    wr_ctl(16'h0018);
    tests++; if (dbg_freeze !== 1'b1 || dbg_cpu_reset !== 1'b1) begin fails++; $display("FAIL frz_rst got %b%b want 11", dbg_freeze, dbg_cpu_reset); end
    rd_ctl(v);
    tests++; if (v !== 16'h0018) begin fails++; $display("FAIL ctl_read got %h want 0018", v); end
    dbg_din = 16'h001A; ctl_reg_wr = 1; brk_halt = 4'b1000; clk1(); idle();
    clk1();
    rd_stat(v);
    tests++; if (dbg_halt_cmd !== 1'b1 || v[1] !== 1'b0) begin fails++; $display("FAIL rst_hold got halt=%b flag=%b want 1 0", dbg_halt_cmd, v[1]); end
    cpu_halt_st = 0; #1;
    tests++; if (dbg_freeze !== 1'b0) begin fails++; $display("FAIL frz_follows_halt got %b want 0", dbg_freeze); end
    cpu_halt_st = 1;
    wr_ctl(16'h0000);
    wr_ctl(16'h0004);
    tests++; if (dbg_halt_cmd !== 1'b0) begin fails++; $display("FAIL step_enter got %b want 0", dbg_halt_cmd); end
    wr_ctl(16'h0010);
    clk1();
    rd_stat(v);
    tests++; if (dbg_halt_cmd !== 1'b1 || v[3:1] !== 3'b000) begin fails++; $display("FAIL rst_abort_step got halt=%b flags=%b want 1 000", dbg_halt_cmd, v[3:1]); end
    wr_ctl(16'h0000);
  endtask

  task automatic test_por_mid_step();
    logic [15:0] v;
    wr_ctl(16'h000C);
    tests++; if (dbg_halt_cmd !== 1'b0 || dbg_freeze !== 1'b1) begin fails++; $display("FAIL por_pre got halt=%b frz=%b want 0 1", dbg_halt_cmd, dbg_freeze); end
    clk1();
    #1 por_n = 0; model_reset();
    #1;
    tests++; if ({dbg_halt_cmd, dbg_freeze, dbg_cpu_reset} !== 3'b000 || ctl_dout !== 16'h0) begin fails++; $display("FAIL por_async got %b%b%b dout=%h want 000 0000", dbg_halt_cmd, dbg_freeze, dbg_cpu_reset, ctl_dout); end
    clk1();
    por_n = 1;
    clk1(); clk1();
    rd_stat(v);
    tests++; if (dbg_halt_cmd !== 1'b0 || v !== 16'h0001) begin fails++; $display("FAIL por_release got halt=%b stat=%h want 0 0001", dbg_halt_cmd, v); end
  endtask

  task automatic test_random();
    logic [15:0] e_d;
    por_n = 0; idle(); clk1(); por_n = 1; clk1();
    for (int c = 0; c < 600; c++) begin
      ctl_reg_wr = ($urandom % 6) == 0;
      dbg_din = 16'($urandom);
      if ($urandom % 4 != 0) dbg_din[4] = 1'b0;
      stat_reg_wr = ($urandom % 8) == 0;
      brk_halt = ($urandom % 10 == 0) ? NB'($urandom) : '0;
      brk_pnd = NB'($urandom);
      cpu_halt_st = ($urandom % 4) != 0;
      exec_done = ($urandom % 7) == 0;
      ctl_reg_rd = $urandom % 2;
      stat_reg_rd = $urandom % 2;
      #1;
      e_d = 16'h0;
      if (ctl_reg_rd) e_d = e_d | (16'(m_rst) << 4) | (16'(m_frz) << 3);
      if (stat_reg_rd) e_d = e_d | (16'(brk_pnd) << 4) | (16'(m_tf) << 3) | (16'(m_df) << 2) | (16'(m_bf) << 1) | 16'(cpu_halt_st);
      tests++; if (dbg_halt_cmd !== (m_st == 1)) begin fails++; $display("FAIL rnd_halt cyc=%0d got %b want %b", c, dbg_halt_cmd, m_st == 1); end
      tests++; if (dbg_freeze !== (cpu_halt_st & m_frz)) begin fails++; $display("FAIL rnd_frz cyc=%0d got %b want %b", c, dbg_freeze, cpu_halt_st & m_frz); end
      tests++; if (dbg_cpu_reset !== m_rst) begin fails++; $display("FAIL rnd_rst cyc=%0d got %b want %b", c, dbg_cpu_reset, m_rst); end
      tests++; if (ctl_dout !== e_d) begin fails++; $display("FAIL rnd_dout cyc=%0d got %h want %h", c, ctl_dout, e_d); end
      clk1();
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_halt_run();
    test_brk();
    test_step_done();
    test_step_timeout();
    test_cmd_prio();
    test_freeze_rst();
    test_por_mid_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
